// File: rtl/counter_core.sv
// counter_core: parametrised timer/counter with prescaler, up/down count, limit, parallel load
// and an IDLE/RUN/DONE control FSM. Define COUNTER_CMP_EN to build the registered compare-match output.
module counter_core #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      cmp_val,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  busy,
  output logic                  done,
  output logic                  cmp_match
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0]            MODE_ONESHOT = 2'b01;
  localparam logic [1:0]            MODE_RELOAD  = 2'b10;
  localparam logic [WIDTH-1:0]      CNT_ONE      = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE      = PRESCALE_W'(1);

  state_t                state;
  state_t                state_nxt;
  logic [PRESCALE_W-1:0] pcnt;
  logic                  stop_acc;
  logic                  start_acc;
  logic                  tick;
  logic                  fire;
  logic                  terminal;
  logic [WIDTH-1:0]      count_step;
  logic [WIDTH-1:0]      count_wrap;

  // A tick is swallowed by a same-cycle load or stop, so neither count nor tc moves then.
  always_comb begin
    stop_acc   = stop && (state != IDLE);
    start_acc  = start && !stop && (state != RUN);
    tick       = busy && en && (pcnt == prescale);
    fire       = tick && !load && !stop_acc;
    terminal   = dir ? (count == '0) : (count == limit);
    count_step = dir ? (count - CNT_ONE) : (count + CNT_ONE);
    count_wrap = dir ? limit : '0;

    state_nxt = state;
    if (stop_acc) begin
      state_nxt = IDLE;
    end else if (start_acc) begin
      state_nxt = RUN;
    end else if (fire && terminal && (mode == MODE_ONESHOT)) begin
      state_nxt = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      tc    <= 1'b0;
      pcnt  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
      tc    <= fire && terminal;

      if (load || start_acc || tick) begin
        pcnt <= '0;
      end else if (busy && en) begin
        pcnt <= pcnt + PRE_ONE;
      end

      // ONESHOT terminal deliberately leaves count at the terminal value.
      if (load) begin
        count <= load_val;
      end else if (fire) begin
        if (!terminal) begin
          count <= count_step;
        end else if (mode == MODE_RELOAD) begin
          count <= load_val;
        end else if (mode != MODE_ONESHOT) begin
          count <= count_wrap;
        end
      end
    end
  end

`ifdef COUNTER_CMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_match <= 1'b0;
    end else begin
      cmp_match <= (count == cmp_val);
    end
  end
`else
  logic unused_cmp_val;
  assign unused_cmp_val = ^cmp_val;
  assign cmp_match      = 1'b0;
`endif

endmodule

// File: tb/tb_counter_core.sv
// tb_counter_core: vector table and hand sequences for the counter_core corner cases, followed by
// randomized stimulus checked against a behavioural model of the counter.
`timescale 1ns/1ps
module tb_counter_core;
  localparam int W    = 8;
  localparam int PW   = 8;
  localparam int MOD  = 1 << W;
  localparam int PMOD = 1 << PW;

`ifdef COUNTER_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          start;
  logic          stop;
  logic          dir;
  logic [1:0]    mode;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  limit;
  logic [PW-1:0] prescale;
  logic [W-1:0]  cmp_val;
  logic [W-1:0]  count;
  logic          tc;
  logic          busy;
  logic          done;
  logic          cmp_match;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_core #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .mode      (mode),
    .load      (load),
    .load_val  (load_val),
    .limit     (limit),
    .prescale  (prescale),
    .cmp_val   (cmp_val),
    .count     (count),
    .tc        (tc),
    .busy      (busy),
    .done      (done),
    .cmp_match (cmp_match)
  );

  typedef struct {
    logic          en;
    logic          start;
    logic          stop;
    logic          dir;
    logic [1:0]    mode;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  limit;
    logic [PW-1:0] prescale;
    logic [W-1:0]  e_count;
    logic          e_tc;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: running/done flags, integer count and prescaler.
  int m_count;
  int m_pcnt;
  bit m_run;
  bit m_done;
  bit m_tc;
  bit m_cmp;

  task automatic modelReset();
    m_count = 0;
    m_pcnt  = 0;
    m_run   = 1'b0;
    m_done  = 1'b0;
    m_tc    = 1'b0;
    m_cmp   = 1'b0;
  endtask

  task automatic modelStep();
    bit stopping, starting, tick_now, fire, at_end, go_done;
    int nxt;
    stopping = stop && (m_run || m_done);
    starting = start && !stop && !m_run;
    tick_now = m_run && en && (m_pcnt == int'(prescale));
    fire     = tick_now && !load && !stopping;
    at_end   = dir ? (m_count == 0) : (m_count == int'(limit));
    go_done  = 1'b0;
    nxt      = m_count;
    m_cmp    = CMP_EN && (m_count == int'(cmp_val));
    m_tc     = fire && at_end;
    if (load) begin
      nxt = int'(load_val);
    end else if (fire && at_end) begin
      if (mode == 2'b01)      go_done = 1'b1;
      else if (mode == 2'b10) nxt = int'(load_val);
      else                    nxt = dir ? int'(limit) : 0;
    end else if (fire) begin
      nxt = dir ? (m_count + MOD - 1) % MOD : (m_count + 1) % MOD;
    end
    if (load || starting || tick_now) m_pcnt = 0;
    else if (m_run && en)             m_pcnt = (m_pcnt + 1) % PMOD;
    if (stopping) begin
      m_run  = 1'b0;
      m_done = 1'b0;
    end else if (starting) begin
      m_run  = 1'b1;
      m_done = 1'b0;
    end else if (go_done) begin
      m_run  = 1'b0;
      m_done = 1'b1;
    end
    m_count = nxt;
  endtask

  task automatic applyStimulus(input logic a_en, input logic a_start, input logic a_stop,
                               input logic a_dir, input logic [1:0] a_mode, input logic a_load,
                               input logic [W-1:0] a_load_val, input logic [W-1:0] a_limit,
                               input logic [PW-1:0] a_prescale);
    en       = a_en;
    start    = a_start;
    stop     = a_stop;
    dir      = a_dir;
    mode     = a_mode;
    load     = a_load;
    load_val = a_load_val;
    limit    = a_limit;
    prescale = a_prescale;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] e_count, input logic e_tc,
                             input logic e_busy, input logic e_done, input logic e_cmp,
                             input bit cmp_care);
    checks++;
    if (count !== e_count || tc !== e_tc || busy !== e_busy || done !== e_done ||
        (cmp_care && cmp_match !== e_cmp)) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got count=%0d tc=%b busy=%b done=%b cmp=%b, expected count=%0d tc=%b busy=%b done=%b cmp=%b",
               name, $time, count, tc, busy, done, cmp_match, e_count, e_tc, e_busy, e_done, e_cmp);
    end
  endtask

  task automatic stepClock(input bit use_model);
    @(posedge clk);
    if (use_model) modelStep();
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    cmp_val = 8'd7;
    rst_n   = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0);
    #12;
    checkOutput("reset_state", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // en start stop dir mode load load_val limit prescale | count tc busy done
    vecs.push_back('{1, 0, 0, 0, 2'b00, 1, 8'd2, 8'd5, 8'd0, 8'd2, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 1, 2'b00, 0, 8'd2, 8'd5, 8'd0, 8'd2, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 1, 2'b00, 0, 8'd2, 8'd5, 8'd0, 8'd1, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 1, 2'b00, 0, 8'd2, 8'd5, 8'd0, 8'd0, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 1, 2'b00, 0, 8'd2, 8'd5, 8'd0, 8'd5, 1, 1, 0});
    vecs.push_back('{1, 0, 0, 1, 2'b00, 0, 8'd2, 8'd5, 8'd0, 8'd4, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 1, 2'b00, 0, 8'd2, 8'd5, 8'd0, 8'd3, 0, 1, 0});
    vecs.push_back('{1, 0, 1, 1, 2'b00, 0, 8'd2, 8'd5, 8'd0, 8'd3, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 2'b01, 1, 8'd0, 8'd3, 8'd3, 8'd0, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 0, 2'b01, 0, 8'd0, 8'd3, 8'd3, 8'd0, 0, 1, 0});
    for (int r = 0; r < 3; r++) vecs.push_back('{1, 0, 0, 0, 2'b01, 0, 8'd0, 8'd3, 8'd3, 8'd0, 0, 1, 0});
    for (int v = 1; v <= 3; v++) begin
      for (int r = 0; r < 4; r++) vecs.push_back('{1, 0, 0, 0, 2'b01, 0, 8'd0, 8'd3, 8'd3, W'(v), 0, 1, 0});
    end
    vecs.push_back('{1, 0, 0, 0, 2'b01, 0, 8'd0, 8'd3, 8'd3, 8'd3, 1, 0, 1});
    vecs.push_back('{1, 0, 0, 0, 2'b01, 0, 8'd0, 8'd3, 8'd3, 8'd3, 0, 0, 1});
    vecs.push_back('{1, 1, 0, 0, 2'b01, 0, 8'd0, 8'd3, 8'd0, 8'd3, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 2'b01, 0, 8'd0, 8'd3, 8'd0, 8'd3, 1, 0, 1});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].start, vecs[i].stop, vecs[i].dir, vecs[i].mode,
                    vecs[i].load, vecs[i].load_val, vecs[i].limit, vecs[i].prescale);
      stepClock(1'b0);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_tc, vecs[i].e_busy,
                  vecs[i].e_done, 1'b0, 1'b0);
    end

    $display("[TB] full-range WRAP up");
    resetDut();
    applyStimulus(1, 1, 0, 0, 2'b00, 0, 8'd0, 8'd255, 8'd0);
    stepClock(1'b0);
    checkOutput("wrap_start", 8'd0, 0, 1, 0, 0, 1'b0);
    applyStimulus(1, 0, 0, 0, 2'b00, 0, 8'd0, 8'd255, 8'd0);
    for (int i = 1; i < 256; i++) begin
      stepClock(1'b0);
      checkOutput("wrap_up", W'(i), 0, 1, 0, 0, 1'b0);
    end
    stepClock(1'b0);
    checkOutput("wrap_tc", 8'd0, 1, 1, 0, 0, 1'b0);
    stepClock(1'b0);
    checkOutput("wrap_after", 8'd1, 0, 1, 0, 0, 1'b0);

    $display("[TB] RELOAD and stop+start");
    resetDut();
    applyStimulus(1, 0, 0, 0, 2'b10, 1, 8'd10, 8'd12, 8'd0);
    stepClock(1'b0);
    checkOutput("reload_load", 8'd10, 0, 0, 0, 0, 1'b0);
    applyStimulus(1, 1, 0, 0, 2'b10, 0, 8'd10, 8'd12, 8'd0);
    stepClock(1'b0);
    checkOutput("reload_start", 8'd10, 0, 1, 0, 0, 1'b0);
    applyStimulus(1, 0, 0, 0, 2'b10, 0, 8'd10, 8'd12, 8'd0);
    stepClock(1'b0);
    checkOutput("reload_11", 8'd11, 0, 1, 0, 0, 1'b0);
    stepClock(1'b0);
    checkOutput("reload_12", 8'd12, 0, 1, 0, 0, 1'b0);
    stepClock(1'b0);
    checkOutput("reload_tc", 8'd10, 1, 1, 0, 0, 1'b0);
    stepClock(1'b0);
    checkOutput("reload_11b", 8'd11, 0, 1, 0, 0, 1'b0);
    applyStimulus(1, 1, 1, 0, 2'b10, 0, 8'd10, 8'd12, 8'd0);
    stepClock(1'b0);
    checkOutput("stop_start", 8'd11, 0, 0, 0, 0, 1'b0);
    applyStimulus(1, 0, 0, 0, 2'b10, 0, 8'd10, 8'd12, 8'd0);
    stepClock(1'b0);
    checkOutput("idle_frozen", 8'd11, 0, 0, 0, 0, 1'b0);

    $display("[TB] async reset mid-run and enable freeze");
    resetDut();
    applyStimulus(1, 1, 0, 0, 2'b00, 0, 8'd0, 8'd255, 8'd1);
    stepClock(1'b0);
    applyStimulus(1, 0, 0, 0, 2'b00, 0, 8'd0, 8'd255, 8'd1);
    stepClock(1'b0);
    stepClock(1'b0);
    checkOutput("pre_reset", 8'd1, 0, 1, 0, 0, 1'b0);
    rst_n = 1'b0;
    #2;
    checkOutput("async_reset", 8'd0, 0, 0, 0, 0, 1'b1);
    rst_n = 1'b1;
    applyStimulus(1, 1, 0, 0, 2'b00, 0, 8'd0, 8'd255, 8'd1);
    stepClock(1'b0);
    checkOutput("ps1_start", 8'd0, 0, 1, 0, 0, 1'b0);
    applyStimulus(1, 0, 0, 0, 2'b00, 0, 8'd0, 8'd255, 8'd1);
    stepClock(1'b0);
    checkOutput("ps1_wait", 8'd0, 0, 1, 0, 0, 1'b0);
    stepClock(1'b0);
    checkOutput("ps1_tick", 8'd1, 0, 1, 0, 0, 1'b0);
    stepClock(1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stepClock(1'b0);
      checkOutput("en_freeze", 8'd1, 0, 1, 0, 0, 1'b0);
    end
    en = 1'b1;
    stepClock(1'b0);
    checkOutput("en_resume", 8'd2, 0, 1, 0, 0, 1'b0);

    $display("[TB] compare match");
    resetDut();
    cmp_val = 8'd7;
    applyStimulus(1, 1, 0, 0, 2'b00, 0, 8'd0, 8'd255, 8'd0);
    stepClock(1'b0);
    checkOutput("cmp_start", 8'd0, 0, 1, 0, 0, 1'b1);
    applyStimulus(1, 0, 0, 0, 2'b00, 0, 8'd0, 8'd255, 8'd0);
    for (int i = 1; i <= 12; i++) begin
      stepClock(1'b0);
      checkOutput("cmp_run", W'(i), 0, 1, 0, CMP_EN && (i == 8), 1'b1);
    end

    $display("[TB] randomized run against model");
    resetDut();
    modelReset();
    limit    = 8'd6;
    load_val = 8'd3;
    prescale = 8'd0;
    for (int i = 0; i < 4000; i++) begin
      en    = ($urandom_range(0, 7) != 0);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      load  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) dir  = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) limit    = W'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) load_val = W'($urandom_range(0, 25));
      if ($urandom_range(0, 63) == 0) prescale = PW'($urandom_range(0, 2));
      cmp_val = W'($urandom_range(0, 12));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rand_reset", 8'd0, 0, 0, 0, 0, 1'b1);
        rst_n = 1'b1;
      end
      stepClock(1'b1);
      checkOutput("random", W'(m_count), m_tc, m_run, m_done, m_cmp, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
